// File: rtl/if_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : if_bus_master
//  Purpose  : Instruction-fetch bus master. It takes the fetch address and
//             fetch enable from the IF-stage PC register and runs one
//             non-pipelined Wishbone-classic read for each instruction. The
//             fetched word comes back with a one-cycle valid pulse. While a
//             read is outstanding, the PC is held through a combinational
//             stall request.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_WIDTH  bus / PC address width
//    TIMEOUT     cycles a read may stay unacknowledged before abort (2..255)
//    NOP_INST    instruction substituted on timeout or bus error
//  Ports
//    clk_i         in   clock, all logic on the rising edge
//    rst_i         in   synchronous reset, active-low
//    pc_i          in   fetch address from the PC register
//    ce_i          in   fetch enable from the PC register
//    flush_i       in   jump/interrupt flush; current fetch is wrong-path
//    stall_req_o   out  combinational; 1 = hold the PC
//    inst_o        out  last delivered instruction
//    inst_valid_o  out  one-cycle pulse, inst_o updated this cycle
//    err_o         out  one-cycle pulse on timeout or bus error
//    wb_adr_o      out  registered read address
//    wb_cyc_o      out  registered bus cycle
//    wb_stb_o      out  registered strobe (always equal to wb_cyc_o)
//    wb_we_o       out  tied 0 (read-only master)
//    wb_sel_o      out  tied 4'b1111
//    wb_dat_i      in   read data
//    wb_ack_i      in   read acknowledge
//    wb_err_i      in   bus error terminating the cycle
// ============================================================================
module if_bus_master #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          TIMEOUT    = 16,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  ce_i,
    input  logic                  flush_i,
    output logic                  stall_req_o,
    output logic [31:0]           inst_o,
    output logic                  inst_valid_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [3:0]            wb_sel_o,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i
);

    // Last counter value of a cycle that is allowed to stay unacknowledged.
    // The counter is 0 in the launch cycle, so reaching this value means the
    // strobe has been high for exactly TIMEOUT cycles.
    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state and next-state values
    // ------------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_cnt;
    logic [7:0]            w_cnt_nxt;
    logic [31:0]           r_inst;
    logic [31:0]           w_inst_nxt;
    logic                  r_inst_valid;
    logic                  w_inst_valid_nxt;
    logic                  r_err;
    logic                  w_err_nxt;
    logic                  r_cyc;
    logic                  w_cyc_nxt;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [ADDR_WIDTH-1:0] w_adr_nxt;
    logic                  w_stall;
    logic                  w_timeout_hit;

    // The >= comparison keeps the abort path safe even if the counter ever
    // passed the limit. In normal operation the counter stops at equality.
    assign w_timeout_hit = (r_cnt >= c_timeout_last);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 8'd0;
            r_inst       <= 32'd0;
            r_inst_valid <= 1'b0;
            r_err        <= 1'b0;
            r_cyc        <= 1'b0;
            r_adr        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_err        <= w_err_nxt;
            r_cyc        <= w_cyc_nxt;
            r_adr        <= w_adr_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_inst_nxt       = r_inst;
        w_inst_valid_nxt = 1'b0;
        w_err_nxt        = 1'b0;
        w_cyc_nxt        = r_cyc;
        w_adr_nxt        = r_adr;
        w_stall          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // A flush in this cycle means pc_i still holds the old path.
                // Do not launch; the redirected PC arrives next cycle.
                w_stall = ce_i & ~flush_i;
                if (ce_i && !flush_i) begin
                    w_adr_nxt   = pc_i;
                    w_cyc_nxt   = 1'b1;
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = ST_BUSY;
                end
            end

            ST_BUSY: begin
                // The PC may advance in the same cycle that the read
                // terminates. This gives two cycles per instruction.
                w_stall = ~(wb_ack_i | wb_err_i | w_timeout_hit);
                if (wb_err_i) begin
                    w_cyc_nxt        = 1'b0;
                    w_inst_nxt       = NOP_INST;
                    w_inst_valid_nxt = 1'b1;
                    w_err_nxt        = 1'b1;
                    w_state_nxt      = ST_IDLE;
                end else if (wb_ack_i) begin
                    w_cyc_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                    // An ack that coincides with a flush returns wrong-path
                    // data. Drop it silently.
                    if (!flush_i) begin
                        w_inst_nxt       = wb_dat_i;
                        w_inst_valid_nxt = 1'b1;
                    end
                end else if (w_timeout_hit) begin
                    // Abort here even if a flush arrives in the same cycle.
                    // This keeps the strobe from exceeding TIMEOUT cycles.
                    // A flushed abort reports the error but delivers nothing,
                    // as a DISCARD timeout would.
                    w_cyc_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                    if (!flush_i) begin
                        w_inst_nxt       = NOP_INST;
                        w_inst_valid_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                    if (flush_i) begin
                        // Classic Wishbone cannot cancel a cycle. Keep the
                        // strobe up and swallow whatever the slave returns.
                        w_state_nxt = ST_DISCARD;
                    end
                end
            end

            ST_DISCARD: begin
                // Hold the PC so that the redirected address is still
                // presented when the bus frees up. Further flushes are
                // ignored.
                w_stall = 1'b1;
                if (wb_err_i || wb_ack_i || w_timeout_hit) begin
                    w_cyc_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = wb_err_i | (~wb_ack_i & w_timeout_hit);
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end

            default: begin
                w_cyc_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign stall_req_o  = w_stall;
    assign inst_o       = r_inst;
    assign inst_valid_o = r_inst_valid;
    assign err_o        = r_err;
    assign wb_adr_o     = r_adr;
    assign wb_cyc_o     = r_cyc;
    assign wb_stb_o     = r_cyc;
    assign wb_we_o      = 1'b0;
    assign wb_sel_o     = 4'b1111;

endmodule
`default_nettype wire

// File: tb/tb_if_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_bus_master
//  Purpose  : Directed self-checking bench for if_bus_master (TIMEOUT = 8).
//             Expected deliveries are queued when the slave response is
//             driven. A monitor pops and compares them on every
//             inst_valid_o / err_o pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_bus_master;

    localparam int          c_aw  = 32;
    localparam int          c_to  = 8;
    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [c_aw-1:0] pc_i;
    logic            ce_i;
    logic            flush_i;
    logic            stall_req_o;
    logic [31:0]     inst_o;
    logic            inst_valid_o;
    logic            err_o;
    logic [c_aw-1:0] wb_adr_o;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [3:0]      wb_sel_o;
    logic [31:0]     wb_dat_i;
    logic            wb_ack_i;
    logic            wb_err_i;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } exp_t;
    exp_t sb[$];

    if_bus_master #(
        .ADDR_WIDTH (c_aw),
        .TIMEOUT    (c_to),
        .NOP_INST   (c_nop)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pc_i         (pc_i),
        .ce_i         (ce_i),
        .flush_i      (flush_i),
        .stall_req_o  (stall_req_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .err_o        (err_o),
        .wb_adr_o     (wb_adr_o),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_we_o      (wb_we_o),
        .wb_sel_o     (wb_sel_o),
        .wb_dat_i     (wb_dat_i),
        .wb_ack_i     (wb_ack_i),
        .wb_err_i     (wb_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge. Inputs are driven here.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard monitor: every delivery or error pulse must match the
    // oldest queued expectation.
    always @(negedge clk_i) begin
        if (rst_i === 1'b1 && (inst_valid_o === 1'b1 || err_o === 1'b1)) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL sb_unexpected observed valid=%b err=%b inst=%h expected no pulse",
                       inst_valid_o, err_o, inst_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                tests++;
                assert ({inst_valid_o, err_o, inst_o} === {1'b1, e.err, e.inst}) else begin
                    fails++;
                    $error("FAIL sb_delivery observed valid=%b err=%b inst=%h expected valid=1 err=%b inst=%h",
                           inst_valid_o, err_o, inst_o, e.err, e.inst);
                end
            end
        end
    end

    initial begin
        rst_i    = 1'b0;
        pc_i     = '0;
        ce_i     = 1'b1;
        flush_i  = 1'b0;
        wb_dat_i = 32'h1234_5678;
        wb_ack_i = 1'b1;
        wb_err_i = 1'b0;

        // ---------------- Reset with ce and ack asserted ----------------
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_cyc",   {63'd0, wb_cyc_o},     64'd0);
        chk("rst_stb",   {63'd0, wb_stb_o},     64'd0);
        chk("rst_valid", {63'd0, inst_valid_o}, 64'd0);
        chk("rst_err",   {63'd0, err_o},        64'd0);
        chk("rst_inst",  {32'd0, inst_o},       64'd0);
        chk("rst_adr",   {32'd0, wb_adr_o},     64'd0);
        chk("tie_we_sel", {59'd0, wb_we_o, wb_sel_o}, {59'd0, 1'b0, 4'b1111});

        // Release the reset with ce low, so no launch occurs.
        tick();
        rst_i    = 1'b1;
        ce_i     = 1'b0;
        wb_ack_i = 1'b0;
        @(negedge clk_i);
        chk("idle_noce_stall", {63'd0, stall_req_o}, 64'd0);

        // ---------------- Zero-wait fetch at PC 0 -----------------------
        tick();
        chk("idle_noce_cyc", {63'd0, wb_cyc_o}, 64'd0);
        ce_i = 1'b1;
        pc_i = 32'h0;
        @(negedge clk_i);
        chk("zw_stall_idle", {63'd0, stall_req_o}, 64'd1);
        tick();                                   // launch edge
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0050_0093;
        sb.push_back('{inst: 32'h0050_0093, err: 1'b0});
        @(negedge clk_i);
        chk("zw_cyc",         {63'd0, wb_cyc_o},    64'd1);
        chk("zw_adr",         {32'd0, wb_adr_o},    64'h0);
        chk("zw_stall_busy",  {63'd0, stall_req_o}, 64'd0);
        tick();                                   // valid cycle, PC advanced
        wb_ack_i = 1'b0;
        pc_i     = 32'h4;
        @(negedge clk_i);
        chk("zw_valid",       {63'd0, inst_valid_o}, 64'd1);
        chk("zw_cyc_drop",    {63'd0, wb_cyc_o},     64'd0);
        chk("zw_stall_next",  {63'd0, stall_req_o},  64'd1);

        // ---------------- Wait-state fetch at PC 4 ----------------------
        tick();                                   // launch edge
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                wb_ack_i = 1'b1;
                wb_dat_i = 32'h00A0_0113;
                sb.push_back('{inst: 32'h00A0_0113, err: 1'b0});
            end
            @(negedge clk_i);
            chk($sformatf("ws_cyc_%0d", i),   {63'd0, wb_cyc_o},    64'd1);
            chk($sformatf("ws_adr_%0d", i),   {32'd0, wb_adr_o},    64'h4);
            chk($sformatf("ws_stall_%0d", i), {63'd0, stall_req_o}, (i != 3) ? 64'd1 : 64'd0);
            if (i != 3) tick();
        end
        tick();
        wb_ack_i = 1'b0;
        pc_i     = 32'h8;
        @(negedge clk_i);
        chk("ws_valid",    {63'd0, inst_valid_o}, 64'd1);
        chk("ws_cyc_drop", {63'd0, wb_cyc_o},     64'd0);

        // ---------------- Flush while a read is in flight ---------------
        tick();                                   // launch at 0x8
        flush_i = 1'b1;
        @(negedge clk_i);
        chk("fl_adr",        {32'd0, wb_adr_o},    64'h8);
        chk("fl_stall_busy", {63'd0, stall_req_o}, 64'd1);
        tick();                                   // DISCARD
        flush_i = 1'b0;
        pc_i    = 32'h100;
        @(negedge clk_i);
        chk("fl_stall_d0", {63'd0, stall_req_o}, 64'd1);
        chk("fl_cyc_d0",   {63'd0, wb_cyc_o},    64'd1);
        tick();
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        chk("fl_stall_d1", {63'd0, stall_req_o}, 64'd1);
        tick();                                   // back to IDLE, no valid
        wb_ack_i = 1'b0;
        @(negedge clk_i);
        chk("fl_no_valid", {63'd0, inst_valid_o}, 64'd0);
        chk("fl_inst_hold", {32'd0, inst_o},      64'h00A0_0113);
        chk("fl_cyc_drop", {63'd0, wb_cyc_o},     64'd0);

        // ---------------- Timeout, slave never acks ---------------------
        tick();                                   // launch at 0x100
        for (int i = 0; i < c_to; i++) begin
            if (i == c_to - 1) sb.push_back('{inst: c_nop, err: 1'b1});
            @(negedge clk_i);
            if (i == 0) chk("to_adr", {32'd0, wb_adr_o}, 64'h100);
            chk($sformatf("to_cyc_%0d", i),   {63'd0, wb_cyc_o},    64'd1);
            chk($sformatf("to_stall_%0d", i), {63'd0, stall_req_o}, (i != c_to - 1) ? 64'd1 : 64'd0);
            tick();
        end
        ce_i = 1'b0;
        @(negedge clk_i);
        chk("to_cyc_drop", {63'd0, wb_cyc_o},            64'd0);
        chk("to_pulse",    {62'd0, inst_valid_o, err_o}, 64'd3);
        chk("to_inst",     {32'd0, inst_o},              {32'd0, c_nop});

        // ---------------- Bus error in the second BUSY cycle ------------
        tick();
        ce_i = 1'b1;
        pc_i = 32'h200;
        tick();                                   // launch at 0x200
        ce_i = 1'b0;
        @(negedge clk_i);
        chk("be_adr", {32'd0, wb_adr_o}, 64'h200);
        tick();
        wb_err_i = 1'b1;
        sb.push_back('{inst: c_nop, err: 1'b1});
        @(negedge clk_i);
        chk("be_stall", {63'd0, stall_req_o}, 64'd0);
        tick();
        wb_err_i = 1'b0;
        wb_ack_i = 1'b1;                          // late ack in IDLE
        wb_dat_i = 32'hCAFE_F00D;
        @(negedge clk_i);
        chk("be_pulse",    {62'd0, inst_valid_o, err_o}, 64'd3);
        chk("be_cyc_drop", {63'd0, wb_cyc_o},            64'd0);
        tick();
        wb_ack_i = 1'b0;
        @(negedge clk_i);
        chk("late_ack_no_valid", {62'd0, inst_valid_o, err_o}, 64'd0);
        chk("late_ack_inst",     {32'd0, inst_o},              {32'd0, c_nop});
        tick();
        @(negedge clk_i);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
